sync_fifo_256w_128d: RTL and testbench
======================================

// Module: sync_fifo_256w_128d
// PURPOSE
//  Single-clock standard-read (non-FWFT) FIFO, 256 bits x 128 entries, buffering HBM read beats
//  ahead of the dispatch stage. Data is written with wr_en and popped with rd_en. A popped word
//  appears on dout one cycle later, qualified by valid. prog_full gives upstream early backpressure.
// PARAMETERS
//  DATA_W            256  data width in bits
//  DEPTH             128  storage entries; must be a power of two
//  PROG_FULL_THRESH  96   prog_full asserts when count >= this value; legal range 1..DEPTH
//  ADDR_W            $clog2(DEPTH) = 7  local constant, not overridable
// PORTS
//  user_clk   in   1        single clock for all logic
//  hbm_rstn   in   1        asynchronous active-low reset
//  din        in   DATA_W   write data
//  wr_en      in   1        write request
//  rd_en      in   1        read request
//  dout       out  DATA_W   read data, registered
//  full       out  1        count == DEPTH
//  empty      out  1        count == 0
//  valid      out  1        dout holds a word popped in the previous cycle
//  prog_full  out  1        count >= PROG_FULL_THRESH
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (hbm_rstn=0, asynchronous assert, sync release by the user):
//    wr_ptr=rd_ptr=0, count=0, empty=1, full=0, prog_full=0, valid=0, dout=0.
//    RAM contents are not cleared. Requests while in reset are ignored.
//    A reset mid-stream discards all stored data and drops valid in the same cycle.
//  - Accepted write: we = wr_en & ~full. Stores din at mem[wr_ptr]; wr_ptr increments mod DEPTH.
//  - Accepted read: re = rd_en & ~empty. On the next edge, dout <= mem[rd_ptr], valid <= 1,
//    and rd_ptr increments mod DEPTH. Read latency is 1 cycle.
//  - Any cycle without re: valid <= 0 and dout holds its last value.
//  - Write while full: dropped. Read while empty: ignored, valid=0. No error flags for either.
//  - Simultaneous we and re: count is unchanged.
//  - Write into an empty FIFO: that word is readable at the earliest on the following cycle,
//    because empty drops one cycle after the write.
//  - Simultaneous rd_en and wr_en while full: the read is accepted and the write is dropped
//    (full gates writes on the registered count).
//  - count is ADDR_W+1 bits. full, empty and prog_full are registered, derived from next-count,
//    and update in the same edge as the pointers.
//  - Pointer wrap 127 -> 0 is transparent; the FIFO remains strictly FIFO-ordered across wraps.
// STRUCTURE
//  - Shared package fifo_pkg: DATA_W, DEPTH and PROG_FULL_THRESH defaults,
//    typedef logic [DATA_W-1:0] fifo_word_t.
//  - One sub-module, fifo_sdp_ram: simple dual-port RAM, DEPTH x DATA_W.
//    One write port, one registered-read port, both on user_clk, no reset, infers BRAM.
//  - The top level holds the pointers, count, flags and the valid register.
// TESTING
//  1. Reset check: hold hbm_rstn=0 for 10 cycles, then release.
//     -> empty=1, full=0, prog_full=0, valid=0, dout=0.
//  2. Ordered pass-through: write 1..50 back-to-back, then hold rd_en.
//     -> valid=1 for exactly 50 cycles, dout=1..50 in order, each one cycle after rd_en,
//     then empty=1.
//  3. Fill to full: write 130 words (0..129) with no reads.
//     -> prog_full rises on the write that makes count=96; full rises at count=128.
//     -> words 128 and 129 are dropped; draining returns 0..127 only.
//  4. Read on empty: with the FIFO empty, pulse rd_en for 5 cycles.
//     -> valid stays 0, dout unchanged, pointers unchanged.
//  5. Steady state with wrap: write and read every cycle for 300 cycles, starting from count=3.
//     -> count stays 3, no flag toggles, output sequence equals input sequence across pointer wraps.
//  6. Reset mid-stream: with count=40 and valid=1, assert hbm_rstn=0 asynchronously, then release.
//     -> valid drops immediately, empty=1; a fresh write of 0xA5 reads back 0xA5.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the HBM read-beat FIFO.
package fifo_pkg;

    localparam int unsigned DATA_W           = 256;
    localparam int unsigned DEPTH            = 128;
    localparam int unsigned PROG_FULL_THRESH = 96;

    typedef logic [DATA_W-1:0] fifo_word_t;

endpackage : fifo_pkg

// File: rtl/sync_fifo_256w_128d_if.sv
// Write/read handshake and status bundle between the producer and the FIFO.
interface sync_fifo_256w_128d_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W
);

    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              valid;
    logic              prog_full;

    // Producer/consumer side
    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, valid, prog_full
    );

    // FIFO side
    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, valid, prog_full
    );

endinterface : sync_fifo_256w_128d_if

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset (BRAM-friendly).
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W,
    parameter int unsigned DEPTH  = fifo_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and enabled read register; rdata holds when re is low
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifo_sdp_ram

// File: rtl/sync_fifo_256w_128d.sv
// Standard-read (non-FWFT) FIFO buffering HBM read beats ahead of dispatch.
module sync_fifo_256w_128d
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W           = fifo_pkg::DATA_W,
    parameter int unsigned DEPTH            = fifo_pkg::DEPTH,
    parameter int unsigned PROG_FULL_THRESH = fifo_pkg::PROG_FULL_THRESH
) (
    input  logic                  user_clk,
    input  logic                  hbm_rstn,
    sync_fifo_256w_128d_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_q;
    logic              empty_q;
    logic              prog_full_q;
    logic              valid_q;
    logic              rd_seen_q;
    logic              we_c;
    logic              re_c;
    logic [DATA_W-1:0] ram_rdata;

    // Accept qualification on registered flags and next occupancy
    always_comb begin
        we_c      = bus.wr_en & ~full_q;
        re_c      = bus.rd_en & ~empty_q;
        count_nxt = count;
        case ({we_c, re_c})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy, flags and the read-valid register
    always_ff @(posedge user_clk or negedge hbm_rstn) begin
        if (!hbm_rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            prog_full_q <= 1'b0;
            valid_q     <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            if (we_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (re_c) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                rd_seen_q <= 1'b1;
            end
            count       <= count_nxt;
            full_q      <= (count_nxt == CNT_W'(DEPTH));
            empty_q     <= (count_nxt == '0);
            prog_full_q <= (count_nxt >= CNT_W'(PROG_FULL_THRESH));
            valid_q     <= re_c;
        end
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (user_clk),
        .we     (we_c),
        .waddr  (wr_ptr),
        .wdata  (bus.din),
        .re     (re_c),
        .raddr  (rd_ptr),
        .rdata  (ram_rdata)
    );

    // The RAM register has no reset, so dout is forced to zero until the first pop after reset
    assign bus.dout      = ram_rdata & {DATA_W{rd_seen_q}};
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.prog_full = prog_full_q;
    assign bus.valid     = valid_q;

endmodule : sync_fifo_256w_128d

// File: tb/tb_sync_fifo_256w_128d.sv
// Randomised self-checking bench for sync_fifo_256w_128d against a queue model.
module tb_sync_fifo_256w_128d;
    import fifo_pkg::*;

    localparam int unsigned M_DEPTH  = 128;
    localparam int unsigned M_THRESH = 96;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_256w_128d_if bus ();

    sync_fifo_256w_128d dut (
        .user_clk (clk),
        .hbm_rstn (rstn),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    fifo_word_t q[$];
    fifo_word_t exp_dout  = '0;
    logic       exp_valid = 1'b0;

    task automatic check_eq(input string tag, input fifo_word_t got, input fifo_word_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, ":valid"},     fifo_word_t'(bus.valid),     fifo_word_t'(exp_valid));
        check_eq({ph, ":empty"},     fifo_word_t'(bus.empty),     fifo_word_t'(q.size() == 0));
        check_eq({ph, ":full"},      fifo_word_t'(bus.full),      fifo_word_t'(q.size() == M_DEPTH));
        check_eq({ph, ":prog_full"}, fifo_word_t'(bus.prog_full), fifo_word_t'(q.size() >= M_THRESH));
        check_eq({ph, ":dout"},      bus.dout,                    exp_dout);
    endtask

    function automatic fifo_word_t rand_word();
        fifo_word_t w;
        for (int i = 0; i < 8; i++) begin
            w[i*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    // One clock: drive requests, let the edge happen, advance the model, then compare
    task automatic step(input string ph, input logic wr, input logic rd, input fifo_word_t d);
        bit acc_w;
        bit acc_r;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.din   = d;
        @(posedge clk);
        if (rstn) begin
            acc_w = wr && (q.size() < M_DEPTH);
            acc_r = rd && (q.size() != 0);
            if (acc_r) begin
                exp_dout  = q.pop_front();
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            if (acc_w) begin
                q.push_back(d);
            end
        end
        #1 check_outputs(ph);
    endtask

    task automatic drain(input string ph);
        int guard = 0;
        while (q.size() != 0 && guard < 300) begin
            step(ph, 1'b0, 1'b1, rand_word());
            guard++;
        end
        if (q.size() != 0) begin
            check_eq({ph, ":drain_timeout"}, fifo_word_t'(q.size()), '0);
        end
        step(ph, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int pw;
        int pr;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;

        // Reset held 10 cycles with requests toggling; they must be ignored
        for (int i = 0; i < 10; i++) begin
            step("reset", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_word());
        end
        @(negedge clk);
        rstn = 1'b1;
        step("post_reset", 1'b0, 1'b0, '0);

        // Ordered pass-through 1..50
        for (int i = 1; i <= 50; i++) begin
            step("pass_wr", 1'b1, 1'b0, fifo_word_t'(i));
        end
        for (int i = 0; i < 53; i++) begin
            step("pass_rd", 1'b0, 1'b1, '0);
        end

        // Fill past full with 0..129, then drain
        for (int i = 0; i < 130; i++) begin
            step("fill", 1'b1, 1'b0, fifo_word_t'(i));
        end
        check_eq("fill:count", fifo_word_t'(q.size()), fifo_word_t'(M_DEPTH));
        // Read and write together while full: read accepted, write dropped
        step("full_rw", 1'b1, 1'b1, fifo_word_t'(999));
        drain("drain");

        // Read on empty
        for (int i = 0; i < 5; i++) begin
            step("rd_empty", 1'b0, 1'b1, '0);
        end

        // Steady state from count=3 across pointer wraps
        for (int i = 0; i < 3; i++) begin
            step("steady_pre", 1'b1, 1'b0, rand_word());
        end
        for (int i = 0; i < 300; i++) begin
            step("steady", 1'b1, 1'b1, rand_word());
        end
        check_eq("steady:count", fifo_word_t'(q.size()), fifo_word_t'(3));
        drain("steady_drain");

        // Random traffic with shifting write/read bias
        for (int phase = 0; phase < 4; phase++) begin
            pw = (phase == 0) ? 80 : (phase == 1) ? 30 : (phase == 2) ? 95 : 50;
            pr = (phase == 0) ? 30 : (phase == 1) ? 80 : (phase == 2) ? 20 : 50;
            for (int i = 0; i < 400; i++) begin
                step("random", 1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                     rand_word());
            end
        end
        drain("random_drain");

        // Reset mid-stream with count=40 and valid=1
        for (int i = 0; i < 41; i++) begin
            step("mid_fill", 1'b1, 1'b0, rand_word());
        end
        step("mid_pop", 1'b0, 1'b1, '0);
        check_eq("mid:count", fifo_word_t'(q.size()), fifo_word_t'(40));
        #2 rstn = 1'b0;
        q.delete();
        exp_valid = 1'b0;
        exp_dout  = '0;
        #1 check_outputs("async_rst");
        for (int i = 0; i < 3; i++) begin
            step("in_reset", 1'b1, 1'b1, rand_word());
        end
        @(negedge clk);
        rstn = 1'b1;
        step("after_rst", 1'b1, 1'b0, fifo_word_t'(8'hA5));
        step("after_rst", 1'b0, 1'b1, '0);
        check_eq("a5_readback", bus.dout, fifo_word_t'(8'hA5));
        step("after_rst", 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo_256w_128d
